// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared widths, FSM states and constants for the
// pipeline hazard control unit.
package pipe_hazard_ctrl_pkg;

    localparam int PC_WIDTH      = 32;
    localparam int REG_IDX_WIDTH = 5;

    localparam logic [PC_WIDTH-1:0] PC_INCR = PC_WIDTH'(4);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MC_WAIT = 2'd1,
        ST_FLUSH   = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_loaduse_det.sv
// Load-use hazard comparator: the EX load's rd is
// read by the instruction currently in ID.
module hazard_loaduse_det
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [REG_IDX_WIDTH-1:0] id_rs1_idx_i,
    input  logic                     id_rs1_ren_i,
    input  logic [REG_IDX_WIDTH-1:0] id_rs2_idx_i,
    input  logic                     id_rs2_ren_i,
    input  logic                     id_ex_valid_i,
    input  logic                     id_ex_is_load_i,
    input  logic [REG_IDX_WIDTH-1:0] id_ex_rd_idx_i,
    input  logic                     id_ex_rd_en_i,
    output logic                     loaduse_o
);

    logic w_ld_wr;
    logic w_rs1_hit;
    logic w_rs2_hit;

    // x0 is never a real dependency
    always_comb begin
        w_ld_wr   = id_ex_valid_i & id_ex_is_load_i & id_ex_rd_en_i
                  & (id_ex_rd_idx_i != '0);
        w_rs1_hit = id_rs1_ren_i & (id_rs1_idx_i == id_ex_rd_idx_i);
        w_rs2_hit = id_rs2_ren_i & (id_rs2_idx_i == id_ex_rd_idx_i);
        loaduse_o = w_ld_wr & (w_rs1_hit | w_rs2_hit);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/redirect controller for IF/ID and ID/EX:
// load-use bubbles, mul/div hold with watchdog, mispredicts.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH  = 32,
    parameter int MC_TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [REG_IDX_WIDTH-1:0] id_rs1_idx_i,
    input  logic                     id_rs1_ren_i,
    input  logic [REG_IDX_WIDTH-1:0] id_rs2_idx_i,
    input  logic                     id_rs2_ren_i,
    input  logic                     id_ex_valid_i,
    input  logic                     id_ex_is_load_i,
    input  logic [REG_IDX_WIDTH-1:0] id_ex_rd_idx_i,
    input  logic                     id_ex_rd_en_i,
    input  logic [PC_WIDTH-1:0]      id_ex_pc_i,
    input  logic                     id_ex_prdt_taken_i,
    input  logic                     ex_br_valid_i,
    input  logic                     ex_br_taken_i,
    input  logic [PC_WIDTH-1:0]      ex_br_target_i,
    input  logic                     ex_mc_start_i,
    input  logic                     ex_mc_done_i,
    output logic                     pc_stall_o,
    output logic                     if_id_stall_o,
    output logic                     id_ex_stall_o,
    output logic                     if_id_flush_o,
    output logic                     id_ex_flush_o,
    output logic                     redirect_valid_o,
    output logic [PC_WIDTH-1:0]      redirect_pc_o,
    output logic                     mc_timeout_o,
    output logic [CNT_WIDTH-1:0]     stall_cnt_o
);

    localparam int MCW = $clog2(MC_TIMEOUT);
    localparam logic [MCW-1:0] MC_LAST = MCW'(MC_TIMEOUT - 1);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [MCW-1:0]   r_mc_cnt;
    logic [MCW-1:0]   w_mc_cnt_nxt;
    logic [CNT_WIDTH-1:0] r_stall_cnt;
    logic             w_loaduse;
    logic             w_mispredict;

    hazard_loaduse_det u_loaduse (
        .id_rs1_idx_i    (id_rs1_idx_i),
        .id_rs1_ren_i    (id_rs1_ren_i),
        .id_rs2_idx_i    (id_rs2_idx_i),
        .id_rs2_ren_i    (id_rs2_ren_i),
        .id_ex_valid_i   (id_ex_valid_i),
        .id_ex_is_load_i (id_ex_is_load_i),
        .id_ex_rd_idx_i  (id_ex_rd_idx_i),
        .id_ex_rd_en_i   (id_ex_rd_en_i),
        .loaduse_o       (w_loaduse)
    );

    assign w_mispredict = ex_br_valid_i
                        & (ex_br_taken_i != id_ex_prdt_taken_i);

    // State, watchdog counter and stall-cycle counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_mc_cnt    <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_mc_cnt <= w_mc_cnt_nxt;
            if (if_id_stall_o)
                r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
        end
    end

    // Next state and zero-latency pipeline controls
    always_comb begin
        w_state_nxt      = r_state;
        w_mc_cnt_nxt     = r_mc_cnt;
        pc_stall_o       = 1'b0;
        if_id_stall_o    = 1'b0;
        id_ex_stall_o    = 1'b0;
        if_id_flush_o    = 1'b0;
        id_ex_flush_o    = 1'b0;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = '0;
        mc_timeout_o     = 1'b0;
        if (rst_n) begin
            case (r_state)
                ST_RUN: begin
                    if (w_mispredict) begin
                        redirect_valid_o = 1'b1;
                        if_id_flush_o    = 1'b1;
                        id_ex_flush_o    = 1'b1;
                        redirect_pc_o    = ex_br_taken_i ? ex_br_target_i
                                         : id_ex_pc_i + PC_INCR;
                        w_state_nxt      = ST_FLUSH;
                    end else if (ex_mc_start_i) begin
                        pc_stall_o    = 1'b1;
                        if_id_stall_o = 1'b1;
                        id_ex_stall_o = 1'b1;
                        if (!ex_mc_done_i) begin
                            w_state_nxt  = ST_MC_WAIT;
                            w_mc_cnt_nxt = MCW'(1);
                        end
                    end else if (w_loaduse) begin
                        pc_stall_o    = 1'b1;
                        if_id_stall_o = 1'b1;
                        id_ex_flush_o = 1'b1;
                    end
                end
                ST_MC_WAIT: begin
                    if (ex_mc_done_i) begin
                        w_state_nxt = ST_RUN;
                    end else if (r_mc_cnt == MC_LAST) begin
                        mc_timeout_o = 1'b1;
                        w_state_nxt  = ST_RUN;
                    end else begin
                        pc_stall_o    = 1'b1;
                        if_id_stall_o = 1'b1;
                        id_ex_stall_o = 1'b1;
                        w_mc_cnt_nxt  = r_mc_cnt + MCW'(1);
                    end
                end
                ST_FLUSH: begin
                    if_id_flush_o = 1'b1;
                    w_state_nxt   = ST_RUN;
                end
                default: w_state_nxt = ST_RUN;
            endcase
        end
    end

    assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: one default
// instance and one with a short watchdog.
module tb_pipe_hazard_ctrl;
    import pipe_hazard_ctrl_pkg::*;

    localparam logic [6:0] F_NONE = 7'b0000000;
    localparam logic [6:0] F_LU   = 7'b1100100;
    localparam logic [6:0] F_MC   = 7'b1110000;
    localparam logic [6:0] F_MP   = 7'b0001110;
    localparam logic [6:0] F_FL   = 7'b0001000;
    localparam logic [6:0] F_TO   = 7'b0000001;

    logic clk = 1'b0;
    logic rst_n;
    logic [REG_IDX_WIDTH-1:0] rs1_idx, rs2_idx, rd_idx;
    logic rs1_ren, rs2_ren, ex_valid, is_load, rd_en;
    logic [PC_WIDTH-1:0] ex_pc, br_target;
    logic prdt, br_valid, br_taken, mc_start, mc_done;

    logic a_pcs, a_ifs, a_exs, a_iff, a_exf, a_rv, a_to;
    logic [PC_WIDTH-1:0] a_rpc;
    logic [31:0] a_cnt;
    logic b_pcs, b_ifs, b_exs, b_iff, b_exf, b_rv, b_to;
    logic [PC_WIDTH-1:0] b_rpc;
    logic [31:0] b_cnt;

    wire [6:0] fa = {a_pcs, a_ifs, a_exs, a_iff, a_exf, a_rv, a_to};
    wire [6:0] fb = {b_pcs, b_ifs, b_exs, b_iff, b_exf, b_rv, b_to};

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl u_dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1_idx_i(rs1_idx), .id_rs1_ren_i(rs1_ren),
        .id_rs2_idx_i(rs2_idx), .id_rs2_ren_i(rs2_ren),
        .id_ex_valid_i(ex_valid), .id_ex_is_load_i(is_load),
        .id_ex_rd_idx_i(rd_idx), .id_ex_rd_en_i(rd_en),
        .id_ex_pc_i(ex_pc), .id_ex_prdt_taken_i(prdt),
        .ex_br_valid_i(br_valid), .ex_br_taken_i(br_taken),
        .ex_br_target_i(br_target),
        .ex_mc_start_i(mc_start), .ex_mc_done_i(mc_done),
        .pc_stall_o(a_pcs), .if_id_stall_o(a_ifs),
        .id_ex_stall_o(a_exs), .if_id_flush_o(a_iff),
        .id_ex_flush_o(a_exf), .redirect_valid_o(a_rv),
        .redirect_pc_o(a_rpc), .mc_timeout_o(a_to),
        .stall_cnt_o(a_cnt)
    );

    pipe_hazard_ctrl #(.CNT_WIDTH(32), .MC_TIMEOUT(4)) u_wd (
        .clk(clk), .rst_n(rst_n),
        .id_rs1_idx_i(rs1_idx), .id_rs1_ren_i(rs1_ren),
        .id_rs2_idx_i(rs2_idx), .id_rs2_ren_i(rs2_ren),
        .id_ex_valid_i(ex_valid), .id_ex_is_load_i(is_load),
        .id_ex_rd_idx_i(rd_idx), .id_ex_rd_en_i(rd_en),
        .id_ex_pc_i(ex_pc), .id_ex_prdt_taken_i(prdt),
        .ex_br_valid_i(br_valid), .ex_br_taken_i(br_taken),
        .ex_br_target_i(br_target),
        .ex_mc_start_i(mc_start), .ex_mc_done_i(mc_done),
        .pc_stall_o(b_pcs), .if_id_stall_o(b_ifs),
        .id_ex_stall_o(b_exs), .if_id_flush_o(b_iff),
        .id_ex_flush_o(b_exf), .redirect_valid_o(b_rv),
        .redirect_pc_o(b_rpc), .mc_timeout_o(b_to),
        .stall_cnt_o(b_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        rs1_idx = '0; rs2_idx = '0; rd_idx = '0;
        rs1_ren = 0; rs2_ren = 0; ex_valid = 0; is_load = 0; rd_en = 0;
        ex_pc = '0; br_target = '0; prdt = 0; br_valid = 0;
        br_taken = 0; mc_start = 0; mc_done = 0;
    endtask

    task automatic set_lu();
        ex_valid = 1; is_load = 1; rd_en = 1; rd_idx = 5'd5;
        rs1_idx = 5'd5; rs1_ren = 1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr();
        rst_n = 1'b0;
        set_lu();
        br_valid = 1; prdt = 1; ex_pc = 32'h100;
        #2;
        chk("rst_flags", 64'(fa), 64'(F_NONE));
        chk("rst_rpc", 64'(a_rpc), 64'h0);
        chk("rst_cnt", 64'(a_cnt), 64'h0);
        clr();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("run_idle", 64'(fa), 64'(F_NONE));

        set_lu();
        #1;
        chk("lu_flags", 64'(fa), 64'(F_LU));
        tick();
        ex_valid = 0;
        #1;
        chk("lu_bubble", 64'(fa), 64'(F_NONE));
        chk("lu_cnt", 64'(a_cnt), 64'd1);

        clr();
        ex_valid = 1; is_load = 1; rd_en = 1;
        rd_idx = 5'd0; rs1_idx = 5'd0; rs1_ren = 1;
        #1;
        chk("lu_x0", 64'(fa), 64'(F_NONE));
        rd_idx = 5'd5; rs1_ren = 0; rs2_idx = 5'd5; rs2_ren = 0;
        #1;
        chk("lu_noread", 64'(fa), 64'(F_NONE));
        rs2_ren = 1;
        #1;
        chk("lu_rs2", 64'(fa), 64'(F_LU));

        clr();
        br_valid = 1; prdt = 1; br_taken = 0; ex_pc = 32'h100;
        #1;
        chk("mp_nt_flags", 64'(fa), 64'(F_MP));
        chk("mp_nt_pc", 64'(a_rpc), 64'h104);
        tick();
        chk("flush_cyc", 64'(fa), 64'(F_FL));
        tick();
        clr();
        #1;
        chk("flush_done", 64'(fa), 64'(F_NONE));

        set_lu();
        br_valid = 1; prdt = 0; br_taken = 1; br_target = 32'h2000;
        #1;
        chk("mp_t_flags", 64'(fa), 64'(F_MP));
        chk("mp_t_pc", 64'(a_rpc), 64'h2000);
        tick();
        clr();
        #1;
        chk("mp_t_flush", 64'(fa), 64'(F_FL));
        chk("mp_t_cnt", 64'(a_cnt), 64'd1);
        tick();

        mc_start = 1;
        #1;
        chk("mc_c0", 64'(fa), 64'(F_MC));
        tick();
        mc_start = 0;
        #1;
        chk("mc_c1", 64'(fa), 64'(F_MC));
        tick();
        set_lu();
        br_valid = 1; prdt = 1;
        #1;
        chk("mc_c2_ign", 64'(fa), 64'(F_MC));
        tick();
        clr();
        #1;
        chk("mc_c3", 64'(fa), 64'(F_MC));
        tick();
        chk("mc_c4", 64'(fa), 64'(F_MC));
        tick();
        mc_done = 1;
        #1;
        chk("mc_c5_done", 64'(fa), 64'(F_NONE));
        tick();
        clr();
        #1;
        chk("mc_back_run", 64'(fa), 64'(F_NONE));
        chk("mc_cnt", 64'(a_cnt), 64'd6);

        mc_start = 1; mc_done = 1;
        #1;
        chk("mc_1cyc", 64'(fa), 64'(F_MC));
        tick();
        clr();
        #1;
        chk("mc_1cyc_run", 64'(fa), 64'(F_NONE));
        chk("mc_1cyc_cnt", 64'(a_cnt), 64'd7);

        mc_start = 1;
        #1;
        chk("wd_c0", 64'(fb), 64'(F_MC));
        tick();
        mc_start = 0;
        #1;
        chk("wd_c1", 64'(fb), 64'(F_MC));
        tick();
        chk("wd_c2", 64'(fb), 64'(F_MC));
        tick();
        chk("wd_c3_to", 64'(fb), 64'(F_TO));
        tick();
        chk("wd_c4_run", 64'(fb), 64'(F_NONE));
        chk("wd_dut_wait", 64'(fa), 64'(F_MC));

        rst_n = 1'b0;
        #1;
        chk("rst_mid_flags", 64'(fa), 64'(F_NONE));
        chk("rst_mid_cnt", 64'(a_cnt), 64'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_mid_idle", 64'(fa), 64'(F_NONE));
        set_lu();
        #1;
        chk("rst_mid_run", 64'(fa), 64'(F_LU));
        clr();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "bench did not finish");
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline control unit. It is the producer of the stall and flush controls that the IF/ID and ID/EX pipeline registers consume.
- Detects load-use hazards, holds the pipeline while a multi-cycle EX operation (mul/div) runs, and resolves branch mispredictions.
- Resolving a misprediction means issuing a fetch redirect and squashing wrong-path instructions.
- Sits beside the ID and EX stages; drives the PC register, the IF/ID register and the ID/EX register.

Parameters:
- CNT_WIDTH, 32, width of the stall-cycle performance counter.
- MC_TIMEOUT, 64, maximum cycles spent in MC_WAIT before the watchdog fires; must be at least 2.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- id_rs1_idx_i  in  `REG_IDX_WIDTH  rs1 index of the instruction in ID.
- id_rs1_ren_i  in  1  ID instruction reads rs1.
- id_rs2_idx_i  in  `REG_IDX_WIDTH  rs2 index of the instruction in ID.
- id_rs2_ren_i  in  1  ID instruction reads rs2.
- id_ex_valid_i  in  1  ID/EX register holds a real instruction (not a bubble).
- id_ex_is_load_i  in  1  EX instruction is a load.
- id_ex_rd_idx_i  in  `REG_IDX_WIDTH  EX destination register.
- id_ex_rd_en_i  in  1  EX instruction writes rd.
- id_ex_pc_i  in  `PC_WIDTH  PC of the EX instruction.
- id_ex_prdt_taken_i  in  1  fetch-time prediction for the EX instruction.
- ex_br_valid_i  in  1  EX is resolving a branch or jump this cycle.
- ex_br_taken_i  in  1  actual direction.
- ex_br_target_i  in  `PC_WIDTH  actual taken target.
- ex_mc_start_i  in  1  multi-cycle op launched in EX this cycle.
- ex_mc_done_i  in  1  multi-cycle op result ready this cycle.
- pc_stall_o  out  1  hold the PC.
- if_id_stall_o  out  1  hold the IF/ID register.
- id_ex_stall_o  out  1  hold the ID/EX register.
- if_id_flush_o  out  1  load a bubble into IF/ID.
- id_ex_flush_o  out  1  load a bubble into ID/EX.
- redirect_valid_o  out  1  fetch redirect request.
- redirect_pc_o  out  `PC_WIDTH  redirect address.
- mc_timeout_o  out  1  one-cycle pulse: watchdog expired.
- stall_cnt_o  out  CNT_WIDTH  count of cycles with if_id_stall_o=1.

Behaviour:
- FSM states are RUN, MC_WAIT and FLUSH. Reset value is RUN.
- While rst_n=0:
  - state=RUN, MC counter=0, stall_cnt_o=0.
  - All 1-bit outputs are 0 and redirect_pc_o=0.
  - Reset asserted mid-MC_WAIT or mid-FLUSH returns the FSM to RUN immediately.
- Consumer rule: when flush and stall are both asserted on a register, flush wins (the register loads a bubble).
- mispredict = ex_br_valid_i & (ex_br_taken_i != id_ex_prdt_taken_i). Evaluated only in RUN; ignored in MC_WAIT and FLUSH.
- loaduse = all of the following:
  - id_ex_valid_i & id_ex_is_load_i & id_ex_rd_en_i & (id_ex_rd_idx_i != 0), and
  - (id_rs1_ren_i & rs1==rd) | (id_rs2_ren_i & rs2==rd).
- RUN, priority is mispredict > ex_mc_start_i > loaduse:
  - mispredict, same cycle (combinational):
    - redirect_valid_o=1, if_id_flush_o=1, id_ex_flush_o=1.
    - redirect_pc_o = ex_br_target_i if ex_br_taken_i, else id_ex_pc_i+4 (modulo 2^PC_WIDTH).
    - Next state FLUSH.
  - ex_mc_start_i, same cycle: pc_stall_o=if_id_stall_o=id_ex_stall_o=1.
    - If ex_mc_done_i is also 1, stay in RUN (single-cycle completion).
    - Otherwise next state MC_WAIT, counter=1.
  - loaduse: pc_stall_o=1, if_id_stall_o=1, id_ex_flush_o=1. Exactly one bubble per hazard; the hazard clears next cycle because ID/EX then holds a bubble. State stays RUN.
  - none of these: all outputs 0.
- MC_WAIT:
  - pc_stall_o, if_id_stall_o, id_ex_stall_o = ~ex_mc_done_i.
  - On ex_mc_done_i, stalls drop the same cycle and next state is RUN.
  - Else, if counter==MC_TIMEOUT-1: mc_timeout_o=1 for one cycle, stalls drop, next state RUN.
  - Else counter increments.
  - loaduse and ex_br_valid_i are ignored in this state.
- FLUSH: lasts exactly one cycle.
  - if_id_flush_o=1, squashing the wrong-path fetch in flight. All other outputs 0.
  - Next state RUN.
  - A mispredict presented in FLUSH is ignored; EX holds a bubble by construction.
- stall_cnt_o: increments by 1 on every cycle with if_id_stall_o=1. Wraps 2^CNT_WIDTH-1 -> 0. Registered, so visible one cycle later.
- Latency: all stall, flush and redirect outputs are combinational from inputs and state (zero latency). Only the state, MC counter and stall_cnt_o are registered.

Decomposition:
- Shared package / defines.v:
  - FSM state encoding: localparams ST_RUN, ST_MC_WAIT, ST_FLUSH.
  - Existing `PC_WIDTH and `REG_IDX_WIDTH.
  - PC_INCR = 4.
- One natural sub-module: hazard_loaduse_det. It is a combinational comparator producing loaduse.
- FSM, watchdog and perf counter stay in the top module, built on the team's dff primitive.

Test Plan:
- Load-use: EX = load x5 (valid, rd_en); ID reads rs1=x5 -> one cycle with pc_stall=if_id_stall=id_ex_flush=1. Next cycle (id_ex_valid=0) all 0. stall_cnt goes 0->1.
- x0 and no-read cases: load rd=x0 with ID rs1=x0 -> no stall. Load rd=x5 with rs2_idx=x5 but rs2_ren=0 -> no stall.
- Mispredict not-taken: prdt_taken=1, br_taken=0, id_ex_pc=0x100 -> redirect_valid=1, redirect_pc=0x104, both flushes=1. Next cycle only if_id_flush=1, then RUN.
- Mispredict taken plus simultaneous loaduse: prdt=0, taken=1, target=0x2000 -> redirect_pc=0x2000, flushes asserted, no stalls, stall_cnt unchanged.
- Multi-cycle: mc_start at cycle 0, mc_done at cycle 5 -> stalls high cycles 0-4, low at cycle 5, back in RUN. stall_cnt +5.
- Watchdog and reset: MC_TIMEOUT=4, mc_start with no done -> mc_timeout_o pulses at cycle 3, stalls drop, RUN. Separately, rst_n low mid-MC_WAIT -> all outputs 0 immediately, stall_cnt_o=0.
